// File: rtl/pht_predictor.sv
// Branch direction predictor: a table of saturating counters indexed bimodally or
// gshare-style, with a one-cycle prediction path and a non-speculative update port.
module pht_predictor #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned HIST_W  = 4,
  parameter int unsigned GSHARE  = 1,
  parameter int unsigned STAT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               request,
  input  logic [PC_W-1:0]    req_pc,
  output logic               prediction,
  output logic               pred_valid,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               result,
  input  logic [INDEX_W-1:0] res_index,
  input  logic               taken,
  input  logic               res_pred,
  output logic [STAT_W-1:0]  lookups,
  output logic [STAT_W-1:0]  mispredicts
);

  localparam int unsigned      ENTRIES  = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [CTR_W-1:0]   pht [ENTRIES];
  logic [HIST_W-1:0]  ghr;

  logic [INDEX_W-1:0] req_idx_c;
  logic [INDEX_W-1:0] hist_idx_c;
  logic [CTR_W-1:0]   res_ctr_c;
  logic [CTR_W-1:0]   res_ctr_next_c;
  logic [HIST_W-1:0]  ghr_next_c;
  logic               unused_pc_bits;

  // Only the word-aligned index bits of the PC participate in the lookup
  assign unused_pc_bits = ^{req_pc[PC_W-1:INDEX_W+2], req_pc[1:0]};

  // History is zero-extended into the index width; bimodal mode ignores it
  assign hist_idx_c = (GSHARE != 0) ? INDEX_W'(ghr) : '0;
  assign req_idx_c  = req_pc[INDEX_W+1:2] ^ hist_idx_c;

  // Saturating step of the counter being trained
  always_comb begin
    res_ctr_c      = pht[res_index];
    res_ctr_next_c = res_ctr_c;
    if (taken) begin
      if (res_ctr_c != CTR_MAX) res_ctr_next_c = res_ctr_c + CTR_W'(1);
    end else begin
      if (res_ctr_c != '0) res_ctr_next_c = res_ctr_c - CTR_W'(1);
    end
  end

  // Shift-in form also covers a single-bit history register
  assign ghr_next_c = HIST_W'({ghr, taken});

  // Counter table and history; reads below see pre-update contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) pht[i] <= CTR_INIT;
      ghr <= '0;
    end else if (result) begin
      pht[res_index] <= res_ctr_next_c;
      ghr            <= ghr_next_c;
    end
  end

  // Prediction outputs; value and index hold while no request arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prediction <= 1'b0;
      pred_valid <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= request;
      if (request) begin
        prediction <= pht[req_idx_c][CTR_W-1];
        pred_index <= req_idx_c;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookups     <= '0;
      mispredicts <= '0;
    end else begin
      if (request && (lookups != STAT_MAX)) lookups <= lookups + STAT_W'(1);
      if (result && (taken != res_pred) && (mispredicts != STAT_MAX))
        mispredicts <= mispredicts + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_pht_predictor.sv
// Bench for pht_predictor: directed vector table, async reset sequence, then a
// randomized scoreboard run against a gshare instance and a small bimodal instance.
module tb_pht_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        request = 1'b0;
  logic [31:0] req_pc = '0;
  logic        result = 1'b0;
  logic [3:0]  res_index = '0;
  logic        taken = 1'b0;
  logic        res_pred = 1'b0;

  logic        prediction, pred_valid;
  logic [3:0]  pred_index;
  logic [15:0] lookups, mispredicts;
  logic        prediction_s, pred_valid_s;
  logic [3:0]  pred_index_s;
  logic [2:0]  lookups_s, mispredicts_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  pht_predictor u_dut (
    .clk(clk), .rst_n(rst_n), .request(request), .req_pc(req_pc),
    .prediction(prediction), .pred_valid(pred_valid), .pred_index(pred_index),
    .result(result), .res_index(res_index), .taken(taken), .res_pred(res_pred),
    .lookups(lookups), .mispredicts(mispredicts)
  );

  pht_predictor #(.CTR_W(3), .HIST_W(1), .GSHARE(0), .STAT_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .request(request), .req_pc(req_pc),
    .prediction(prediction_s), .pred_valid(pred_valid_s), .pred_index(pred_index_s),
    .result(result), .res_index(res_index), .taken(taken), .res_pred(res_pred),
    .lookups(lookups_s), .mispredicts(mispredicts_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic rq, input logic [31:0] pc, input logic rs,
                       input logic [3:0] ri, input logic tk, input logic rp);
    request   = rq;
    req_pc    = rq ? pc : 'x;
    result    = rs;
    res_index = ri;
    taken     = rs ? tk : 'x;
    res_pred  = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        res;
    logic [3:0]  ridx;
    logic        tkn;
    logic        rpred;
    logic        ev;
    logic        ep;
    logic [3:0]  ei;
    int          el;
    int          em;
  } vec_t;

  function automatic vec_t mk(logic rq, logic [31:0] pc, logic rs, logic [3:0] ri,
                              logic tk, logic rp, logic ev, logic ep, logic [3:0] ei,
                              int el, int em);
    vec_t v;
    v.req = rq; v.pc = pc; v.res = rs; v.ridx = ri; v.tkn = tk; v.rpred = rp;
    v.ev = ev; v.ep = ep; v.ei = ei; v.el = el; v.em = em;
    return v;
  endfunction

  typedef struct {
    logic       p;
    logic [3:0] i;
    logic       ps;
    logic [3:0] is;
  } exp_t;

  exp_t sbq[$];
  int   pht_m[16];
  int   pht_sm[16];
  logic [3:0] ghr_m;
  int   look_m, mis_m;

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  vec_t tv[22];

  initial begin
    // Directed sequence: expected values worked out by hand from reset state
    tv[0]  = mk(1, 32'h40, 0, 4'h0, 0, 0, 1, 0, 4'h0, 1, 0);
    tv[1]  = mk(0, 32'h00, 1, 4'h3, 1, 0, 0, 0, 4'h0, 1, 1);
    tv[2]  = mk(0, 32'h00, 1, 4'h3, 1, 0, 0, 0, 4'h0, 1, 2);
    tv[3]  = mk(0, 32'h00, 1, 4'h3, 1, 0, 0, 0, 4'h0, 1, 3);
    tv[4]  = mk(1, 32'h10, 0, 4'h0, 0, 0, 1, 1, 4'h3, 2, 3);
    tv[5]  = mk(0, 32'h00, 1, 4'h5, 0, 0, 0, 1, 4'h3, 2, 3);
    tv[6]  = mk(0, 32'h00, 1, 4'h5, 0, 0, 0, 1, 4'h3, 2, 3);
    tv[7]  = mk(0, 32'h00, 1, 4'h5, 0, 0, 0, 1, 4'h3, 2, 3);
    tv[8]  = mk(0, 32'h00, 1, 4'h5, 0, 0, 0, 1, 4'h3, 2, 3);
    tv[9]  = mk(1, 32'h14, 0, 4'h0, 0, 0, 1, 0, 4'h5, 3, 3);
    tv[10] = mk(1, 32'h08, 1, 4'h2, 1, 0, 1, 0, 4'h2, 4, 4);
    tv[11] = mk(1, 32'h0C, 0, 4'h0, 0, 0, 1, 1, 4'h2, 5, 4);
    tv[12] = mk(0, 32'h00, 1, 4'h9, 1, 1, 0, 1, 4'h2, 5, 4);
    tv[13] = mk(0, 32'h00, 1, 4'h9, 0, 0, 0, 1, 4'h2, 5, 4);
    tv[14] = mk(0, 32'h00, 1, 4'h9, 1, 1, 0, 1, 4'h2, 5, 4);
    tv[15] = mk(0, 32'h00, 1, 4'h9, 1, 1, 0, 1, 4'h2, 5, 4);
    tv[16] = mk(1, 32'h04, 0, 4'h0, 0, 0, 1, 0, 4'hA, 6, 4);
    tv[17] = mk(0, 32'h00, 1, 4'h7, 1, 1, 0, 0, 4'hA, 6, 4);
    tv[18] = mk(0, 32'h00, 1, 4'h7, 1, 1, 0, 0, 4'hA, 6, 4);
    tv[19] = mk(1, 32'h00, 0, 4'h0, 0, 0, 1, 0, 4'hF, 7, 4);
    tv[20] = mk(1, 32'h00, 0, 4'h0, 0, 0, 1, 0, 4'hF, 8, 4);
    tv[21] = mk(1, 32'h00, 0, 4'h0, 0, 0, 1, 0, 4'hF, 9, 4);

    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_prediction", prediction, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_index", pred_index, 0);
    chk("rst_lookups", lookups, 0);
    chk("rst_mispredicts", mispredicts, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 22; k++) begin
      drive(tv[k].req, tv[k].pc, tv[k].res, tv[k].ridx, tv[k].tkn, tv[k].rpred);
      tick();
      chk($sformatf("v%0d_pred_valid", k), pred_valid, tv[k].ev);
      chk($sformatf("v%0d_prediction", k), prediction, tv[k].ep);
      chk($sformatf("v%0d_pred_index", k), pred_index, tv[k].ei);
      chk($sformatf("v%0d_lookups", k), lookups, tv[k].el);
      chk($sformatf("v%0d_mispredicts", k), mispredicts, tv[k].em);
    end

    // Asynchronous reset mid-cycle while a prediction is still valid
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pred_valid", pred_valid, 0);
    chk("async_prediction", prediction, 0);
    chk("async_pred_index", pred_index, 0);
    chk("async_lookups", lookups, 0);
    chk("async_mispredicts", mispredicts, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h1C, 0, 0, 0, 0);
    tick();
    chk("post_rst_prediction", prediction, 0);
    chk("post_rst_pred_index", pred_index, 7);
    chk("post_rst_lookups", lookups, 1);
    // Stale index after reset is a normal write: PHT[7] 1->2, ghr becomes 1
    drive(0, 0, 1, 4'h7, 1, 0);
    tick();
    chk("stale_upd_mispredicts", mispredicts, 1);
    drive(1, 32'h18, 0, 0, 0, 0);
    tick();
    chk("stale_upd_prediction", prediction, 1);
    chk("stale_upd_pred_index", pred_index, 7);

    // Randomized run with reference model and scoreboard
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 16; e++) begin
      pht_m[e]  = 1;
      pht_sm[e] = 3;
    end
    ghr_m  = '0;
    look_m = 0;
    mis_m  = 0;
    for (int n = 0; n < 400; n++) begin
      logic        rq, rs, tk, rp;
      logic [31:0] pc;
      logic [3:0]  ri, gi, bi;
      exp_t        x, got;
      rq = 1'($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 1));
      tk = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      pc = $urandom;
      ri = 4'($urandom_range(0, 15));
      if (n % 50 < 10) ri = 4'(pc[5:2]);
      drive(rq, pc, rs, ri, tk, rp);
      if (rq) begin
        bi   = pc[5:2];
        gi   = bi ^ ghr_m;
        x.p  = (pht_m[gi] >= 2);
        x.i  = gi;
        x.ps = (pht_sm[bi] >= 4);
        x.is = bi;
        sbq.push_back(x);
        look_m++;
      end
      if (rs) begin
        if (tk) begin
          if (pht_m[ri] < 3) pht_m[ri]++;
          if (pht_sm[ri] < 7) pht_sm[ri]++;
        end else begin
          if (pht_m[ri] > 0) pht_m[ri]--;
          if (pht_sm[ri] > 0) pht_sm[ri]--;
        end
        ghr_m = {ghr_m[2:0], tk};
        if (tk != rp) mis_m++;
      end
      tick();
      chk("rnd_pred_valid", pred_valid, rq);
      chk("rnd_pred_valid_s", pred_valid_s, rq);
      if (pred_valid) begin
        if (sbq.size() == 0) begin
          chk("rnd_sb_underflow", 1, 0);
        end else begin
          got = sbq.pop_front();
          chk("rnd_prediction", prediction, got.p);
          chk("rnd_pred_index", pred_index, got.i);
          chk("rnd_prediction_s", prediction_s, got.ps);
          chk("rnd_pred_index_s", pred_index_s, got.is);
        end
      end
      chk("rnd_lookups", lookups, sat(look_m, 65535));
      chk("rnd_mispredicts", mispredicts, sat(mis_m, 65535));
      chk("rnd_lookups_sat", lookups_s, sat(look_m, 7));
      chk("rnd_mispredicts_sat", mispredicts_s, sat(mis_m, 7));
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("rnd_idle_valid", pred_valid, 0);
    chk("sb_drain", sbq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
